// File: rtl/hazard_unit_seq.sv
// Stateful hazard unit: load-use stalls spanning LOAD_LAT extra cycles, internally
// tracked PC-write pending window, and per-operand M/W forwarding selects.
module hazard_unit_seq #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned LOAD_LAT    = 0,
  parameter int unsigned PC_DEPTH    = 3,
  parameter int unsigned NO_FWD_ADDR = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] ra_d,
  input  logic [NUM_SRC-1:0]        ra_valid_d,
  input  logic [NUM_SRC*ADDR_W-1:0] ra_e,
  input  logic [ADDR_W-1:0]         wa3e,
  input  logic [ADDR_W-1:0]         wa3m,
  input  logic [ADDR_W-1:0]         wa3w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic                      mem_to_reg_e,
  input  logic                      branch_e,
  input  logic                      cond_ex_e,
  input  logic                      pc_src_d,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [NUM_SRC*2-1:0]      fwd_e,
  output logic                      busy
);

  logic [2:0] ld_cnt_q, ld_cnt_d;
  logic [2:0] pc_cnt_q, pc_cnt_d;
  logic       ld_hit, ld_stall, br_taken, pc_cap;

  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ra_valid_d[i] && (ra_d[i*ADDR_W +: ADDR_W] == wa3e))
        ld_hit = 1'b1;
    end
    ld_hit   = ld_hit & mem_to_reg_e;
    ld_stall = ld_hit | (ld_cnt_q != 3'd0);
    br_taken = branch_e & cond_ex_e;
    pc_cap   = pc_src_d & ~ld_stall & ~br_taken & (pc_cnt_q == 3'd0);
  end

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (ld_hit && (ld_cnt_q == 3'd0))
      ld_cnt_d = 3'(LOAD_LAT);
    else if (ld_cnt_q != 3'd0)
      ld_cnt_d = ld_cnt_q - 3'd1;

    pc_cnt_d = pc_cnt_q;
    if (pc_cap)
      pc_cnt_d = 3'(PC_DEPTH);
    else if (pc_cnt_q != 3'd0)
      pc_cnt_d = pc_cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= '0;
      pc_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      pc_cnt_q <= pc_cnt_d;
    end
  end

  // Outputs are gated by rst_n so they read zero throughout reset, not just after the counters clear.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    busy    = 1'b0;
    fwd_e   = '0;
    if (rst_n) begin
      stall_f = ld_stall | pc_src_d | (pc_cnt_q > 3'd1);
      stall_d = ld_stall;
      flush_d = pc_src_d | (pc_cnt_q != 3'd0) | br_taken;
      flush_e = ld_stall | br_taken;
      busy    = (ld_cnt_q != 3'd0) | (pc_cnt_q != 3'd0);
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (reg_write_m && (ra_e[i*ADDR_W +: ADDR_W] == wa3m) &&
            (32'(ra_e[i*ADDR_W +: ADDR_W]) != NO_FWD_ADDR))
          fwd_e[i*2 +: 2] = 2'b10;
        else if (reg_write_w && (ra_e[i*ADDR_W +: ADDR_W] == wa3w) &&
                 (32'(ra_e[i*ADDR_W +: ADDR_W]) != NO_FWD_ADDR))
          fwd_e[i*2 +: 2] = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_seq.sv
// Bench for hazard_unit_seq (LOAD_LAT=2, PC_DEPTH=3): directed plan sequences plus
// randomized traffic checked against a cycle-level reference model.
module tb_hazard_unit_seq;

  localparam int ADDR_W = 4;
  localparam int NSRC   = 2;
  localparam int LLAT   = 2;
  localparam int PCD    = 3;
  localparam int NOFWD  = 15;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NSRC*ADDR_W-1:0] ra_d, ra_e;
  logic [NSRC-1:0]        ra_valid_d;
  logic [ADDR_W-1:0]      wa3e, wa3m, wa3w;
  logic                   reg_write_m, reg_write_w, mem_to_reg_e;
  logic                   branch_e, cond_ex_e, pc_src_d;
  logic                   stall_f, stall_d, flush_d, flush_e, busy;
  logic [NSRC*2-1:0]      fwd_e;

  int checks = 0;
  int failures = 0;
  int m_ld = 0, m_pc = 0;
  int n_sf, n_sd, n_fd, n_fe, n_busy;

  hazard_unit_seq #(
    .ADDR_W(ADDR_W), .NUM_SRC(NSRC), .LOAD_LAT(LLAT), .PC_DEPTH(PCD), .NO_FWD_ADDR(NOFWD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ra_d(ra_d), .ra_valid_d(ra_valid_d), .ra_e(ra_e),
    .wa3e(wa3e), .wa3m(wa3m), .wa3w(wa3w), .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w), .mem_to_reg_e(mem_to_reg_e), .branch_e(branch_e),
    .cond_ex_e(cond_ex_e), .pc_src_d(pc_src_d), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_e(fwd_e), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    ra_d = '0; ra_valid_d = '0; ra_e = '0;
    wa3e = '0; wa3m = '0; wa3w = '0;
    reg_write_m = 0; reg_write_w = 0; mem_to_reg_e = 0;
    branch_e = 0; cond_ex_e = 0; pc_src_d = 0;
  endtask

  task automatic clear_counts();
    n_sf = 0; n_sd = 0; n_fd = 0; n_fe = 0; n_busy = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {stall_f, stall_d, flush_d, flush_e, busy}, 0);
    check({tag, "_fwd"}, int'(fwd_e), 0);
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one clock.
  task automatic step();
    bit hit, lds, br;
    int exp_fwd, ra, nl, np;
    #1;
    hit = 0;
    for (int i = 0; i < NSRC; i++)
      if (ra_valid_d[i] && int'(ra_d[i*ADDR_W +: ADDR_W]) == int'(wa3e)) hit = 1;
    hit = hit && mem_to_reg_e;
    lds = hit || (m_ld > 0);
    br  = branch_e && cond_ex_e;
    exp_fwd = 0;
    for (int i = 0; i < NSRC; i++) begin
      ra = int'(ra_e[i*ADDR_W +: ADDR_W]);
      if (reg_write_m && ra == int'(wa3m) && ra != NOFWD) exp_fwd += 2 * (4 ** i);
      else if (reg_write_w && ra == int'(wa3w) && ra != NOFWD) exp_fwd += 1 * (4 ** i);
    end
    check("stall_f", int'(stall_f), int'(lds || pc_src_d || m_pc > 1));
    check("stall_d", int'(stall_d), int'(lds));
    check("flush_d", int'(flush_d), int'(pc_src_d || m_pc > 0 || br));
    check("flush_e", int'(flush_e), int'(lds || br));
    check("busy", int'(busy), int'(m_ld > 0 || m_pc > 0));
    check("fwd_e", int'(fwd_e), exp_fwd);
    n_sf += int'(stall_f); n_sd += int'(stall_d); n_fd += int'(flush_d);
    n_fe += int'(flush_e); n_busy += int'(busy);
    if (hit && m_ld == 0) nl = LLAT;
    else nl = (m_ld > 0) ? m_ld - 1 : 0;
    if (pc_src_d && !lds && !br && m_pc == 0) np = PCD;
    else np = (m_pc > 0) ? m_pc - 1 : 0;
    @(posedge clk);
    m_ld = nl; m_pc = np;
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    mem_to_reg_e = 1; pc_src_d = 1; branch_e = 1; cond_ex_e = 1;
    reg_write_m = 1;
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    @(negedge clk);
    idle();
    rst_n = 1;
    step();

    // Forwarding priority and the never-forwarded address
    ra_e = {4'd5, 4'd3}; wa3m = 4'd3; reg_write_m = 1; wa3w = 4'd5; reg_write_w = 1;
    #1 check("fwd_m_w", int'(fwd_e), 4'b0110);
    step();
    wa3w = 4'd3;
    #1 check("fwd_m_prio", int'(fwd_e[1:0]), 2);
    step();
    ra_e[3:0] = 4'd15; wa3m = 4'd15; wa3w = 4'd15;
    #1 check("fwd_nofwd", int'(fwd_e[1:0]), 0);
    step();

    // Load-use stall, operand 1 valid then not valid
    idle(); clear_counts();
    mem_to_reg_e = 1; wa3e = 4'd4; ra_d[7:4] = 4'd4; ra_valid_d = 2'b10;
    step();
    idle();
    repeat (5) step();
    check("lu_stall_d_len", n_sd, 3);
    check("lu_stall_f_len", n_sf, 3);
    check("lu_flush_e_len", n_fe, 3);
    clear_counts();
    mem_to_reg_e = 1; wa3e = 4'd4; ra_d[7:4] = 4'd4; ra_valid_d = 2'b00;
    step();
    idle();
    repeat (3) step();
    check("lu_invalid_len", n_sd, 0);

    // PC-write pending window
    clear_counts();
    pc_src_d = 1;
    step();
    idle();
    repeat (6) step();
    check("pc_stall_f_len", n_sf, 3);
    check("pc_flush_d_len", n_fd, 4);
    check("pc_busy_len", n_busy, 3);

    // Taken branch, with and without a coincident PC write
    clear_counts();
    branch_e = 1; cond_ex_e = 1;
    step();
    pc_src_d = 1;
    step();
    idle();
    step();
    check("br_no_capture", n_busy, 0);
    check("br_flush_e_len", n_fe, 2);

    // PC write held through a load-use stall is captured afterwards
    clear_counts();
    mem_to_reg_e = 1; wa3e = 4'd7; ra_d[3:0] = 4'd7; ra_valid_d = 2'b01; pc_src_d = 1;
    step();
    mem_to_reg_e = 0;
    while (busy || stall_d) step();
    check("defer_pre_cap_busy", n_busy, 2);
    step();
    pc_src_d = 0;
    repeat (5) step();
    check("defer_flush_d_len", n_fd, 7);
    check("defer_stall_f_len", n_sf, 6);

    // Async reset with both counters pending
    idle();
    pc_src_d = 1;
    step();
    idle();
    step();
    mem_to_reg_e = 1; wa3e = 4'd2; ra_d[3:0] = 4'd2; ra_valid_d = 2'b01;
    step();
    idle();
    check("pre_reset_busy", int'(busy), 1);
    #2;
    ra_e = {4'd3, 4'd3}; wa3m = 4'd3; reg_write_m = 1; pc_src_d = 1;
    branch_e = 1; cond_ex_e = 1; mem_to_reg_e = 1;
    rst_n = 0;
    #1 check_all_zero("async_reset");
    m_ld = 0; m_pc = 0;
    @(negedge clk);
    idle();
    rst_n = 1;
    repeat (3) begin
      #1 check_all_zero("post_reset_idle");
      step();
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra_d = 8'($urandom); ra_e = 8'($urandom);
      ra_valid_d = 2'($urandom);
      wa3e = 4'($urandom); wa3m = 4'($urandom); wa3w = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ra_e[3:0] = wa3m; ra_e[7:4] = wa3w; ra_d[3:0] = wa3e;
      end
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      mem_to_reg_e = ($urandom_range(0, 3) == 0);
      branch_e = ($urandom_range(0, 4) == 0); cond_ex_e = 1'($urandom);
      pc_src_d = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
